// File: rtl/tea_host_pkg.sv
// ---------------------------------------------------------------------------
// tea_host_pkg
// Shared definitions for the TEA host controller: FSM state encoding,
// the cipher's register map, the start codes placed on the enc_dec lines
// and the write-sequence lengths used by the WR state.
// ---------------------------------------------------------------------------
package tea_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD,
    S_OUT
  } state_t;

  // Cipher register map
  localparam logic [3:0] ADDR_DATA0  = 4'h0;
  localparam logic [3:0] ADDR_DATA1  = 4'h1;
  localparam logic [3:0] ADDR_KEY0   = 4'h2;
  localparam logic [3:0] ADDR_KEY1   = 4'h3;
  localparam logic [3:0] ADDR_KEY2   = 4'h4;
  localparam logic [3:0] ADDR_KEY3   = 4'h5;
  localparam logic [3:0] ADDR_STATUS = 4'h6;
  localparam logic [3:0] ADDR_RES0   = 4'h7;
  localparam logic [3:0] ADDR_RES1   = 4'h8;

  // Start codes driven for exactly one cycle
  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_ENC  = 2'b01;
  localparam logic [1:0] CTRL_DEC  = 2'b10;

  // Index of the last word written in WR: all six words, or data only
  localparam logic [2:0] WR_LAST_FULL = 3'd5;
  localparam logic [2:0] WR_LAST_DATA = 3'd1;

  function automatic logic [1:0] start_code(input logic mode);
    return mode ? CTRL_DEC : CTRL_ENC;
  endfunction

endpackage

// File: rtl/tea_host_ctrl_tmo.sv
// ---------------------------------------------------------------------------
// tea_host_ctrl_tmo
// Saturating timeout counter for the wait-for-completion phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (has priority over en)
//   en         : count one cycle
//   expired    : count has reached TIMEOUT_CYCLES (and stays there)
// ---------------------------------------------------------------------------
module tea_host_ctrl_tmo #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/tea_host_ctrl.sv
// ---------------------------------------------------------------------------
// tea_host_ctrl
// Bus initiator for the TEA cipher's register-mapped slave port. A request
// (block, key, mode) is taken from a valid/ready stream, written into the
// cipher, started, waited on, and the status and result registers are read
// back. The 64-bit result and an error flag leave on a valid/ready stream.
//
// Ports:
//   i_clk, i_rstn           clock, asynchronous active-low reset
//   i_s_valid/o_s_ready     request handshake
//   i_s_block, i_s_key      {v1,v0} and {k3,k2,k1,k0}
//   i_s_mode                0 = encrypt, 1 = decrypt
//   o_m_valid/i_m_ready     result handshake
//   o_m_block, o_m_error    result (zero on error), error flag
//   o_tea_data/addr/we      cipher write/read bus (registered)
//   o_tea_enc_dec           one-cycle start code
//   i_tea_data, i_tea_ready cipher read data (1-cycle latency), ready
//
// Build option TEA_HOST_KEY_CACHE_EN: remember the last key written; when a
// request repeats it, only the two data words are written.
// ---------------------------------------------------------------------------
module tea_host_ctrl
  import tea_host_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [2*WORD_SIZE-1:0] i_s_block,
  input  logic [4*WORD_SIZE-1:0] i_s_key,
  input  logic                   i_s_mode,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output logic [2*WORD_SIZE-1:0] o_m_block,
  output logic                   o_m_error,
  output logic [WORD_SIZE-1:0]   o_tea_data,
  output logic [3:0]             o_tea_addr,
  output logic                   o_tea_we,
  output logic [1:0]             o_tea_enc_dec,
  input  logic [WORD_SIZE-1:0]   i_tea_data,
  input  logic                   i_tea_ready
);

  localparam int W = WORD_SIZE;

  state_t         state;
  logic [W-1:0]   v1_q;
  logic [4*W-1:0] key_q;
  logic           mode_q;
  logic [2:0]     step;
  logic [2:0]     wr_last;
  logic           status_ok;
  logic [W-1:0]   res0_q;
  logic [W-1:0]   next_word;
  logic           accept;
  logic           key_hit;
  logic           tmo_expired;

  assign accept = (state == S_IDLE) && i_s_valid && o_s_ready;

`ifdef TEA_HOST_KEY_CACHE_EN
  logic [4*W-1:0] key_cache;
  logic           cache_valid;

  assign key_hit = cache_valid && (key_cache == i_s_key);

  // Every accepted request leaves its key in the cipher, so it becomes the
  // cached key whether or not it was actually rewritten.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      key_cache   <= '0;
      cache_valid <= 1'b0;
    end else if (accept) begin
      key_cache   <= i_s_key;
      cache_valid <= 1'b1;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  tea_host_ctrl_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .clr     (state == S_START),
    .en      ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)),
    .expired (tmo_expired)
  );

  // Word that follows the one currently on the bus during WR; word 0 is
  // taken straight from the request when it is accepted.
  always_comb begin
    next_word = '0;
    case (step)
      3'd0:    next_word = v1_q;
      3'd1:    next_word = key_q[W-1:0];
      3'd2:    next_word = key_q[2*W-1:W];
      3'd3:    next_word = key_q[3*W-1:2*W];
      3'd4:    next_word = key_q[4*W-1:3*W];
      default: next_word = '0;
    endcase
  end

  // Main sequencer. Bus outputs are set one cycle ahead, so each state's
  // bus activity is visible while the FSM sits in that state. Outside WR
  // and RD the bus parks at address 0 so status (read-to-clear) is never
  // touched by accident.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= S_IDLE;
      o_s_ready     <= 1'b0;
      o_m_valid     <= 1'b0;
      o_m_block     <= '0;
      o_m_error     <= 1'b0;
      o_tea_data    <= '0;
      o_tea_addr    <= ADDR_DATA0;
      o_tea_we      <= 1'b0;
      o_tea_enc_dec <= CTRL_NONE;
      v1_q          <= '0;
      key_q         <= '0;
      mode_q        <= 1'b0;
      step          <= '0;
      wr_last       <= WR_LAST_FULL;
      status_ok     <= 1'b0;
      res0_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_s_ready <= 1'b1;
          if (accept) begin
            o_s_ready  <= 1'b0;
            v1_q       <= i_s_block[2*W-1:W];
            key_q      <= i_s_key;
            mode_q     <= i_s_mode;
            wr_last    <= key_hit ? WR_LAST_DATA : WR_LAST_FULL;
            step       <= '0;
            o_tea_we   <= 1'b1;
            o_tea_addr <= ADDR_DATA0;
            o_tea_data <= i_s_block[W-1:0];
            state      <= S_WR;
          end
        end
        S_WR: begin
          if (step == wr_last) begin
            o_tea_we      <= 1'b0;
            o_tea_addr    <= ADDR_DATA0;
            o_tea_data    <= '0;
            o_tea_enc_dec <= start_code(mode_q);
            state         <= S_START;
          end else begin
            step       <= step + 3'd1;
            o_tea_addr <= 4'(step) + 4'd1;
            o_tea_data <= next_word;
          end
        end
        S_START: begin
          o_tea_enc_dec <= CTRL_NONE;
          state         <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          // Timeout wins over a completion seen in the same cycle.
          if (tmo_expired) begin
            o_m_valid <= 1'b1;
            o_m_error <= 1'b1;
            o_m_block <= '0;
            state     <= S_OUT;
          end else if ((state == S_WAIT_BUSY) && !i_tea_ready) begin
            state <= S_WAIT_DONE;
          end else if ((state == S_WAIT_DONE) && i_tea_ready) begin
            step       <= '0;
            o_tea_addr <= ADDR_STATUS;
            state      <= S_RD;
          end
        end
        S_RD: begin
          // Read data trails the address by one cycle, so each capture
          // belongs to the address presented in the previous step.
          step <= step + 3'd1;
          case (step)
            3'd0: o_tea_addr <= ADDR_RES0;
            3'd1: begin
              status_ok  <= i_tea_data[0];
              o_tea_addr <= ADDR_RES1;
            end
            3'd2: begin
              res0_q     <= i_tea_data;
              o_tea_addr <= ADDR_DATA0;
            end
            default: begin
              o_m_valid <= 1'b1;
              o_m_error <= !status_ok;
              o_m_block <= status_ok ? {i_tea_data, res0_q} : '0;
              state     <= S_OUT;
            end
          endcase
        end
        S_OUT: begin
          if (i_m_ready) begin
            o_m_valid <= 1'b0;
            o_s_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tea_host_ctrl
// Drives tea_host_ctrl against a behavioural TEA cipher slave and checks the
// returned result, error flag, bus traffic and latency against a reference
// computed from plain TEA arithmetic and the controller's documented timing.
// ---------------------------------------------------------------------------
module tb_tea_host_ctrl;

  localparam int W = 32;

  logic           clk;
  logic           rstn;
  logic           s_valid;
  logic           s_ready;
  logic [63:0]    s_block;
  logic [127:0]   s_key;
  logic           s_mode;
  logic           m_valid;
  logic           m_ready;
  logic [63:0]    m_block;
  logic           m_error;
  logic [31:0]    tea_data;
  logic [3:0]     tea_addr;
  logic           tea_we;
  logic [1:0]     tea_enc_dec;
  logic [31:0]    tea_rdata;
  logic           tea_ready;

  tea_host_ctrl #(.WORD_SIZE(W), .TIMEOUT_CYCLES(255)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_s_block     (s_block),
    .i_s_key       (s_key),
    .i_s_mode      (s_mode),
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready),
    .o_m_block     (m_block),
    .o_m_error     (m_error),
    .o_tea_data    (tea_data),
    .o_tea_addr    (tea_addr),
    .o_tea_we      (tea_we),
    .o_tea_enc_dec (tea_enc_dec),
    .i_tea_data    (tea_rdata),
    .i_tea_ready   (tea_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain TEA, 32 cycles; block {v1,v0}, key {k3,k2,k1,k0}
  function automatic logic [63:0] tea_enc(input logic [63:0] blk, input logic [127:0] key);
    logic [31:0] v0, v1, sum;
    v0 = blk[31:0]; v1 = blk[63:32]; sum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + key[31:0]) ^ (v1 + sum) ^ ((v1 >> 5) + key[63:32]));
      v1 = v1 + (((v0 << 4) + key[95:64]) ^ (v0 + sum) ^ ((v0 >> 5) + key[127:96]));
    end
    return {v1, v0};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] blk, input logic [127:0] key);
    logic [31:0] v0, v1, sum;
    v0 = blk[31:0]; v1 = blk[63:32]; sum = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1 = v1 - (((v0 << 4) + key[95:64]) ^ (v0 + sum) ^ ((v0 >> 5) + key[127:96]));
      v0 = v0 - (((v1 << 4) + key[31:0]) ^ (v1 + sum) ^ ((v1 >> 5) + key[63:32]));
      sum = sum - 32'h9E3779B9;
    end
    return {v1, v0};
  endfunction

  // Cipher slave: registered read data, status read-to-clear, ready low for
  // busy_len cycles after a start. 'hang' ignores starts entirely and
  // 'no_done' finishes without setting the status done bit.
  logic        hang, no_done;
  int          busy_len;
  logic [31:0] c_regs [0:8];
  logic        c_busy, c_done;
  int          c_cnt;
  logic [1:0]  c_code;
  logic [63:0] c_res;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 9; i++) c_regs[i] <= '0;
      c_busy <= 1'b0; c_done <= 1'b0; c_cnt <= 0; c_code <= 2'b00;
      tea_ready <= 1'b1; tea_rdata <= '0;
    end else begin
      if (tea_we && tea_addr <= 4'd5) c_regs[tea_addr] <= tea_data;
      if (!tea_we && tea_addr <= 4'd8) begin
        tea_rdata <= (tea_addr == 4'd6) ? {31'b0, c_done} : c_regs[tea_addr];
        if (tea_addr == 4'd6) c_done <= 1'b0;
      end
      if (c_busy) begin
        if (c_cnt <= 1) begin
          if (c_code == 2'b10)
            c_res = tea_dec({c_regs[1], c_regs[0]}, {c_regs[5], c_regs[4], c_regs[3], c_regs[2]});
          else
            c_res = tea_enc({c_regs[1], c_regs[0]}, {c_regs[5], c_regs[4], c_regs[3], c_regs[2]});
          c_regs[7] <= c_res[31:0];
          c_regs[8] <= c_res[63:32];
          c_busy    <= 1'b0;
          tea_ready <= 1'b1;
          c_done    <= !no_done;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end else if (tea_enc_dec != 2'b00 && !hang) begin
        c_busy <= 1'b1; c_cnt <= busy_len; tea_ready <= 1'b0;
        c_code <= tea_enc_dec; c_done <= 1'b0;
      end
    end
  end

  // Bus traffic counters, cleared by the stimulus task at each accept
  int         wr_cnt, rd6_cnt, start_cnt;
  logic [1:0] last_code;

  always @(posedge clk) begin
    if (rstn) begin
      if (tea_we) wr_cnt++;
      if (!tea_we && tea_addr == 4'd6) rd6_cnt++;
      if (tea_enc_dec != 2'b00) begin
        start_cnt++;
        last_code = tea_enc_dec;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
  endtask

  // Reference key cache, only meaningful when the controller keeps one
  logic [127:0] model_key;
  logic         model_key_valid = 1'b0;

  // One full transaction: request, wait for result, optional stall, consume
  // (with a fresh request raised alongside i_m_ready, which must not be taken
  // in that same cycle).
  task automatic applyStimulus(input logic [63:0] block, input logic [127:0] key, input logic mode,
                               input int busy, input int stall, input logic hang_m, input logic nodone_m,
                               output logic [63:0] got);
    int n, lat, exp_writes;
    logic [63:0] exp_blk, held;
    logic exp_err;
    got = '0;
    busy_len = busy; hang = hang_m; no_done = nodone_m;
    @(negedge clk);
    s_block = block; s_key = key; s_mode = mode; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    checkOutput("s_ready_wait", 64'(s_ready), 64'd1);
    if (!s_ready) begin s_valid = 1'b0; return; end
    @(posedge clk); #1;
    s_valid = 1'b0; wr_cnt = 0; rd6_cnt = 0; start_cnt = 0;

    exp_writes = 6;
`ifdef TEA_HOST_KEY_CACHE_EN
    if (model_key_valid && model_key == key) exp_writes = 2;
    model_key = key; model_key_valid = 1'b1;
`endif
    exp_err = hang_m || nodone_m;
    exp_blk = exp_err ? 64'd0 : (mode ? tea_dec(block, key) : tea_enc(block, key));

    lat = 0;
    while (!m_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    checkOutput("m_valid", 64'(m_valid), 64'd1);
    if (!m_valid) return;
    got = m_block;
    checkOutput("block", m_block, exp_blk);
    checkOutput("error", 64'(m_error), 64'(exp_err));
    checkOutput("writes", 64'(wr_cnt), 64'(exp_writes));
    checkOutput("start_pulses", 64'(start_cnt), 64'd1);
    checkOutput("start_code", 64'(last_code), mode ? 64'd2 : 64'd1);
    if (hang_m) begin
      checkOutput("tmo_status_reads", 64'(rd6_cnt), 64'd0);
      checkOutput("tmo_latency_ok", 64'(lat >= exp_writes + 256 && lat <= exp_writes + 258), 64'd1);
    end else begin
      checkOutput("status_reads", 64'(rd6_cnt), 64'd1);
      checkOutput("latency", 64'(lat), 64'(exp_writes + 1 + busy + 4 + 1));
    end

    held = m_block;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", 64'(m_valid), 64'd1);
      checkOutput("stall_block", m_block, held);
      checkOutput("stall_s_ready", 64'(s_ready), 64'd0);
    end

    @(negedge clk);
    m_ready = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0; s_valid = 1'b0;
    checkOutput("consumed", 64'(m_valid), 64'd0);
    checkOutput("idle_ready", 64'(s_ready), 64'd1);
    checkOutput("no_early_accept", 64'(tea_we), 64'd0);
  endtask

  initial begin : main
    logic [63:0]  got, blk;
    logic [127:0] key, prev_key;
    int n;

    s_valid = 1'b0; m_ready = 1'b0; s_block = '0; s_key = '0; s_mode = 1'b0;
    hang = 1'b0; no_done = 1'b0; busy_len = 4;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("reset_ctrl", 64'({s_ready, m_valid, m_error, tea_we, tea_enc_dec, tea_addr}), 64'd0);
    checkOutput("reset_block", m_block, 64'd0);
    checkOutput("reset_data", 64'(tea_data), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    $display("[TB] known-answer encrypt and decrypt with zero key");
    applyStimulus(64'd0, 128'd0, 1'b0, 5, 0, 1'b0, 1'b0, got);
    checkOutput("kat_enc", got, 64'h94BAA940_41EA3A0A);
    blk = got;
    applyStimulus(blk, 128'd0, 1'b1, 3, 0, 1'b0, 1'b0, got);
    checkOutput("kat_dec", got, 64'd0);

    $display("[TB] cipher never completes");
    applyStimulus(64'h0123456789ABCDEF, 128'd7, 1'b0, 4, 0, 1'b1, 1'b0, got);

    $display("[TB] result stalled for 20 cycles");
    applyStimulus(64'hDEADBEEF_CAFEF00D, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, 20, 1'b0, 1'b0, got);

    $display("[TB] status done bit missing");
    applyStimulus(64'h1111_2222_3333_4444, 128'h5, 1'b1, 1, 0, 1'b0, 1'b1, got);

    $display("[TB] reset while waiting for completion");
    busy_len = 40; hang = 1'b0; no_done = 1'b0;
    @(negedge clk);
    s_block = 64'h55AA; s_key = 128'h99; s_mode = 1'b0; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("mid_wait_idle_bus", 64'({m_valid, tea_we, tea_ready}), 64'd0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 64'({s_ready, m_valid, m_error, tea_we, tea_enc_dec, tea_addr}), 64'd0);
    checkOutput("midrst_block", m_block, 64'd0);
    checkOutput("midrst_data", 64'(tea_data), 64'd0);
    model_key_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(64'hA5A5_5A5A_0F0F_F0F0, 128'h99, 1'b0, 3, 1, 1'b0, 1'b0, got);

    $display("[TB] same key twice, then a new key");
    key = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus({$urandom, $urandom}, key, 1'b0, 2, 0, 1'b0, 1'b0, got);
    applyStimulus({$urandom, $urandom}, key, 1'b1, 2, 0, 1'b0, 1'b0, got);
    applyStimulus({$urandom, $urandom}, ~key, 1'b0, 2, 0, 1'b0, 1'b0, got);

    $display("[TB] randomized requests");
    prev_key = ~key;
    for (int t = 0; t < 12; t++) begin
      key = ($urandom_range(0, 1) == 1) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
      applyStimulus({$urandom, $urandom}, key, 1'($urandom_range(0, 1)),
                    $urandom_range(1, 12), $urandom_range(0, 3), 1'b0, 1'b0, got);
      prev_key = key;
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
